// File: rtl/mau_pkg.sv
// mau_pkg: state and access-kind encodings plus timeout counter sizing for mem_access_unit.
package mau_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic [1:0] {FETCH, LOAD, STORE} kind_e;
    function automatic int cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction
endpackage

// File: rtl/mau_if.sv
// mau_if: req/ack memory bus between mem_access_unit (master) and a unified memory (slave).
interface mau_if #(parameter int AW = 32, parameter int DW = 32) ();
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/mau_timeout_ctr.sv
// mau_timeout_ctr: counts enabled cycles since clear; expired on the TIMEOUT-th enabled cycle.
module mau_timeout_ctr
    import mau_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int CW = cnt_w(TIMEOUT);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear_i ? '0 : enable_i ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    assign expired_o = enable_i & (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns controller IRWrite/IorD/MemWrite strobes into one req/ack bus transaction,
// latching IR/MDR and stalling the controller meanwhile. MAU_TIMEOUT_EN adds a BUSY timeout with sticky err.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
`ifdef MAU_TIMEOUT_EN
    , parameter int TIMEOUT = 16
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          IRWrite,
    input  logic          IorD,
    input  logic          MemWrite,
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] alu_out,
    input  logic [DW-1:0] wdata,
    output logic          stall,
    output logic [DW-1:0] ir,
    output logic [DW-1:0] mdr,
    output logic          err,
    mau_if.master         mem
);
    state_e        state_q, state_d;
    kind_e         kind_q, kind_d;
    logic          req_q, req_d, we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, ir_q, ir_d, mdr_q, mdr_d;
    logic          start, expired;
    assign start = IRWrite | IorD;
`ifdef MAU_TIMEOUT_EN
    logic err_q;
    mau_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q != BUSY),
        .enable_i  (state_q == BUSY),
        .expired_o (expired)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_q | (state_q == BUSY & ~mem.mem_ack & expired);
    assign err = err_q;
`else
    assign expired = 1'b0;
    assign err     = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = BUSY;
                req_d   = 1'b1;
                we_d    = IorD & MemWrite;
                kind_d  = !IorD ? FETCH : MemWrite ? STORE : LOAD;
                addr_d  = (IorD ? alu_out : pc) & {{(AW-2){1'b1}}, 2'b00};
                wdata_d = wdata;
            end
            BUSY: if (mem.mem_ack) begin
                state_d = DONE;
                req_d   = 1'b0;
                ir_d    = kind_q == FETCH ? mem.mem_rdata : ir_q;
                mdr_d   = kind_q == LOAD  ? mem.mem_rdata : mdr_q;
            end else if (expired) begin
                state_d = DONE;
                req_d   = 1'b0;
            end
            // DONE always returns to IDLE so a held strobe cannot retrigger
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            kind_q  <= FETCH;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
        end
    assign stall         = (state_q == IDLE & start) | (state_q == BUSY);
    assign ir            = ir_q;
    assign mdr           = mdr_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of fetch/load/store, alignment, reset abort and BUSY timeout.
// Builds with or without MAU_TIMEOUT_EN; the memory responder acks after a programmable wait count.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        IRWrite = 1'b0, IorD = 1'b0, MemWrite = 1'b0;
    logic [31:0] pc = '0, alu_out = '0, wdata = '0;
    logic        stall, err;
    logic [31:0] ir, mdr;
    int          checks = 0, failures = 0;
    int          wait_cfg = 0, wcnt, txn_count;
    logic        ack_en = 1'b1;
    logic [31:0] rdata_cfg = '0;

    mau_if #(.AW(32), .DW(32)) bus ();

    mem_access_unit #(
        .AW(32), .DW(32)
`ifdef MAU_TIMEOUT_EN
        , .TIMEOUT(8)
`endif
    ) dut (
        .clk(clk), .rst(rst), .IRWrite(IRWrite), .IorD(IorD), .MemWrite(MemWrite),
        .pc(pc), .alu_out(alu_out), .wdata(wdata), .stall(stall), .ir(ir), .mdr(mdr),
        .err(err), .mem(bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_ack   = bus.mem_req && ack_en && (wcnt == wait_cfg);
    assign bus.mem_rdata = rdata_cfg;

    always @(posedge clk or negedge rst)
        if (!rst) begin
            wcnt      <= 0;
            txn_count <= 0;
        end else begin
            wcnt      <= (bus.mem_req && !bus.mem_ack) ? wcnt + 1 : 0;
            txn_count <= txn_count + ((bus.mem_req && bus.mem_ack) ? 1 : 0);
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({bus.mem_req, bus.mem_we, stall, err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctl: req/we/stall/err=%b expected 0000", {bus.mem_req, bus.mem_we, stall, err});
        end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || ir !== 32'h0 || mdr !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: addr=%h wdata=%h ir=%h mdr=%h expected all 0", bus.mem_addr, bus.mem_wdata, ir, mdr);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        wait_cfg = 0; rdata_cfg = 32'h2008000A;
        IRWrite = 1'b1; pc = 32'h3000;
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL fetch_stall_T: stall=%b expected 1", stall); end
        tick();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h3000 || bus.mem_we !== 1'b0 || stall !== 1'b1) begin
            failures++;
            $display("FAIL fetch_bus: req=%b addr=%h we=%b stall=%b expected 1 00003000 0 1", bus.mem_req, bus.mem_addr, bus.mem_we, stall);
        end
        tick();
        checks++;
        if (ir !== 32'h2008000A || stall !== 1'b0 || bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL fetch_done: ir=%h stall=%b req=%b expected 2008000a 0 0", ir, stall, bus.mem_req);
        end
        IRWrite = 1'b0;
        tick();
    endtask

    task automatic test_load();
        int stall_cycles = 0;
        wait_cfg = 3; rdata_cfg = 32'hDEADBEEF;
        IorD = 1'b1; alu_out = 32'h1004;
        #1;
        for (int i = 0; i < 20 && stall === 1'b1; i++) begin
            stall_cycles++;
            tick();
        end
        checks++;
        if (stall_cycles != 5) begin failures++; $display("FAIL load_stall_len: got %0d cycles expected 5", stall_cycles); end
        checks++;
        if (mdr !== 32'hDEADBEEF || ir !== 32'h2008000A) begin
            failures++;
            $display("FAIL load_regs: mdr=%h ir=%h expected deadbeef 2008000a", mdr, ir);
        end
        IorD = 1'b0;
        tick();
    endtask

    task automatic test_store();
        wait_cfg = 1; rdata_cfg = 32'hFFFFFFFF;
        IorD = 1'b1; MemWrite = 1'b1; alu_out = 32'h1008; wdata = 32'h55;
        #1;
        tick();
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h55 || bus.mem_addr !== 32'h1008) begin
            failures++;
            $display("FAIL store_bus: we=%b wdata=%h addr=%h expected 1 00000055 00001008", bus.mem_we, bus.mem_wdata, bus.mem_addr);
        end
        repeat (2) tick();
        checks++;
        if (ir !== 32'h2008000A || mdr !== 32'hDEADBEEF || stall !== 1'b0) begin
            failures++;
            $display("FAIL store_regs: ir=%h mdr=%h stall=%b expected 2008000a deadbeef 0", ir, mdr, stall);
        end
        IorD = 1'b0; MemWrite = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int txn0;
        wait_cfg = 0; rdata_cfg = 32'h12345678;
        txn0 = txn_count;
        IorD = 1'b1; alu_out = 32'h1006;
        #1;
        tick();
        checks++;
        if (bus.mem_addr !== 32'h1004) begin failures++; $display("FAIL unaligned_addr: addr=%h expected 00001004", bus.mem_addr); end
        tick();
        checks++;
        if (mdr !== 32'h12345678 || stall !== 1'b0) begin
            failures++;
            $display("FAIL unaligned_load: mdr=%h stall=%b expected 12345678 0", mdr, stall);
        end
        tick();
        IorD = 1'b0;
        repeat (3) tick();
        checks++;
        if (txn_count - txn0 != 1 || bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL single_txn: txns=%0d req=%b expected 1 0", txn_count - txn0, bus.mem_req);
        end
    endtask

    task automatic test_reset_mid();
        wait_cfg = 100;
        IRWrite = 1'b1; pc = 32'h40;
        #1;
        tick();
        checks++;
        if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL mid_busy: req=%b expected 1", bus.mem_req); end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || ir !== 32'h0 || mdr !== 32'h0 || stall !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: req=%b ir=%h mdr=%h stall=%b expected 0 0 0 1", bus.mem_req, ir, mdr, stall);
        end
        IRWrite = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL mid_reset_idle: stall=%b expected 0", stall); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        ack_en = 1'b0;
        IRWrite = 1'b1; pc = 32'h80;
        #1;
        repeat (8) tick();
        checks++;
        if (stall !== 1'b1 || bus.mem_req !== 1'b1) begin
            failures++;
            $display("FAIL to_busy8: stall=%b req=%b expected 1 1", stall, bus.mem_req);
        end
        tick();
`ifdef MAU_TIMEOUT_EN
        checks++;
        if (err !== 1'b1 || stall !== 1'b0 || bus.mem_req !== 1'b0 || ir !== 32'h0) begin
            failures++;
            $display("FAIL to_expire: err=%b stall=%b req=%b ir=%h expected 1 0 0 0", err, stall, bus.mem_req, ir);
        end
        IRWrite = 1'b0;
        repeat (3) tick();
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL to_sticky: err=%b expected 1", err); end
`else
        repeat (20) tick();
        checks++;
        if (stall !== 1'b1 || err !== 1'b0 || bus.mem_req !== 1'b1) begin
            failures++;
            $display("FAIL to_wait: stall=%b err=%b req=%b expected 1 0 1", stall, err, bus.mem_req);
        end
        IRWrite = 1'b0;
`endif
        rst = 1'b0;
        tick();
        rst = 1'b1;
        ack_en = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
